// File: rtl/fifo_sc_pkg.sv
// Shared constants and sizing helpers for the single-clock parametrised FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_sc_pkg;

    // Accepted values of the REGMODE parameter.
    localparam string REGMODE_NOREG  = "NOREG";
    localparam string REGMODE_OUTREG = "OUTREG";

    // Pointers and the word count carry one bit more than the RAM address so
    // that a full FIFO (count == depth) is distinguishable from an empty one.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_sc_ram.sv
// Simple dual-port synchronous RAM backing the FIFO, one write and one read port.
// Latency: read data registered, valid the edge after re_i; write lands on the edge.
// Backpressure: none; the caller gates we_i/re_i. Read-before-write on collision.
//
// Ports: clk_i; we_i/waddr_i/wdat_i write port; re_i/raddr_i read enable and
// address; rdat_o registered read data (holds while re_i is low, not reset).
module fifo_sc_ram
    import fifo_sc_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdat_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdat_o
);

    logic [DATA_WIDTH-1:0] mem_q [fifo_depth(ADDR_WIDTH)];
    logic [DATA_WIDTH-1:0] rdat_q;

    // Both ports sit in one non-blocking block, so a same-address read
    // returns the word stored before this edge's write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdat_i;
        end
        if (re_i) begin
            rdat_q <= mem_q[raddr_i];
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/fifo_sc_param.sv
// Single-clock FIFO, any width, power-of-two depth, programmable AE/AF thresholds.
// Latency: write visible to the reader one edge later; DO 1 edge after a read (2 with OUTREG).
// Backpressure: FF blocks writes and EF blocks reads; refused requests are dropped.
//
// Ports: CLK, RST (async, active-high); DI/WE write side; RE read side; ORE
// output register enable (OUTREG only); RPRST synchronous flush; AEPTR/AFPTR
// thresholds; ERRCLR clears sticky errors; DO read data; CNT word count;
// EF/AEF/AFF/FF status flags; OVF/UDF sticky error flags.
// Build option: define FIFO_SC_ERRFLAG_EN to build the OVF/UDF error registers.
module fifo_sc_param
    import fifo_sc_pkg::*;
#(
    parameter int    DATA_WIDTH = 18,
    parameter int    ADDR_WIDTH = 9,
    parameter string REGMODE    = "NOREG"
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic                  WE,
    input  logic                  RE,
    input  logic                  ORE,
    input  logic                  RPRST,
    input  logic [ADDR_WIDTH:0]   AEPTR,
    input  logic [ADDR_WIDTH:0]   AFPTR,
    input  logic                  ERRCLR,
    output logic [DATA_WIDTH-1:0] DO,
    output logic [ADDR_WIDTH:0]   CNT,
    output logic                  EF,
    output logic                  AEF,
    output logic                  AFF,
    output logic                  FF,
    output logic                  OVF,
    output logic                  UDF
);

    localparam int             CW      = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0]  DEPTH_C = CW'(fifo_depth(ADDR_WIDTH));

    logic [CW-1:0] wp_q, wp_d, rp_q, rp_d, cnt_q, cnt_d;
    logic          ef_q, ef_d, aef_q, aef_d, aff_q, aff_d, ff_q, ff_d;
    logic          do_vld_q;
    logic          wacc, racc;
    logic [DATA_WIDTH-1:0] ram_rdat, ram_dat;

    // A flush owns the read side for its cycle, so a coincident read is dropped.
    assign wacc = WE & ~ff_q;
    assign racc = RE & ~ef_q & ~RPRST;

    always_comb begin
        wp_d = wp_q + CW'(wacc);
        rp_d = rp_q + CW'(racc);
        cnt_d = cnt_q + CW'(wacc) - CW'(racc);
        if (RPRST) begin
            // RP catches up with the pre-write WP, so a word written in the
            // flush cycle survives as the only entry.
            rp_d  = wp_q;
            cnt_d = CW'(wacc);
        end
        ef_d  = (cnt_d == '0);
        ff_d  = (cnt_d == DEPTH_C);
        aef_d = (cnt_d <= AEPTR);
        aff_d = (cnt_d >= AFPTR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            ef_q     <= 1'b1;
            aef_q    <= 1'b1;
            aff_q    <= 1'b0;
            ff_q     <= 1'b0;
            do_vld_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ef_q  <= ef_d;
            aef_q <= aef_d;
            aff_q <= aff_d;
            ff_q  <= ff_d;
            if (racc) begin
                do_vld_q <= 1'b1;
            end
        end
    end

    fifo_sc_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (wacc),
        .waddr_i (wp_q[ADDR_WIDTH-1:0]),
        .wdat_i  (DI),
        .re_i    (racc),
        .raddr_i (rp_q[ADDR_WIDTH-1:0]),
        .rdat_o  (ram_rdat)
    );

    // The RAM read register has no reset; mask it to zero until the first
    // read after reset so DO reads back 0 out of reset.
    assign ram_dat = do_vld_q ? ram_rdat : '0;

    if (REGMODE == REGMODE_OUTREG) begin : g_outreg
        logic [DATA_WIDTH-1:0] out_q;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                out_q <= '0;
            end else if (ORE) begin
                out_q <= ram_dat;
            end
        end
        assign DO = out_q;
    end else begin : g_noreg
        logic unused_ore;
        assign unused_ore = ORE;
        assign DO = ram_dat;
    end

`ifdef FIFO_SC_ERRFLAG_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    // A new error event wins over a coincident clear.
    always_comb begin
        ovf_d = (ovf_q & ~ERRCLR) | (WE & ff_q);
        udf_d = (udf_q & ~ERRCLR) | (RE & ef_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign OVF = ovf_q;
    assign UDF = udf_q;
`else
    logic unused_errclr;
    assign unused_errclr = ERRCLR;
    assign OVF = 1'b0;
    assign UDF = 1'b0;
`endif

    assign CNT = cnt_q;
    assign EF  = ef_q;
    assign AEF = aef_q;
    assign AFF = aff_q;
    assign FF  = ff_q;

endmodule

// File: tb/tb_fifo_sc_param.sv
// Directed self-checking bench: a NOREG and an OUTREG FIFO (8 x 16) share all inputs.
// Latency: inputs change 1 time unit after the rising edge; outputs sampled there too.
// Backpressure: exercised through full/empty refusal, flush and simultaneous read/write.
module tb_fifo_sc_param;

`ifdef FIFO_SC_ERRFLAG_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic       CLK, RST, WE, RE, ORE, RPRST, ERRCLR;
    logic [7:0] DI;
    logic [4:0] AEPTR, AFPTR;
    logic [7:0] DO, DO2;
    logic [4:0] CNT, CNT2;
    logic       EF, AEF, AFF, FF, OVF, UDF;
    logic       EF2, AEF2, AFF2, FF2, OVF2, UDF2;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_sc_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .REGMODE("NOREG")) dut (
        .CLK(CLK), .RST(RST), .DI(DI), .WE(WE), .RE(RE), .ORE(ORE), .RPRST(RPRST),
        .AEPTR(AEPTR), .AFPTR(AFPTR), .ERRCLR(ERRCLR), .DO(DO), .CNT(CNT),
        .EF(EF), .AEF(AEF), .AFF(AFF), .FF(FF), .OVF(OVF), .UDF(UDF)
    );

    fifo_sc_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .REGMODE("OUTREG")) dut_oreg (
        .CLK(CLK), .RST(RST), .DI(DI), .WE(WE), .RE(RE), .ORE(ORE), .RPRST(RPRST),
        .AEPTR(AEPTR), .AFPTR(AFPTR), .ERRCLR(ERRCLR), .DO(DO2), .CNT(CNT2),
        .EF(EF2), .AEF(AEF2), .AFF(AFF2), .FF(FF2), .OVF(OVF2), .UDF(UDF2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; WE = 1'b0; RE = 1'b0; ORE = 1'b0; RPRST = 1'b0; ERRCLR = 1'b0;
        DI = 8'h00; AEPTR = 5'd2; AFPTR = 5'd14;
        #3;
        check("rst_cnt", 32'(CNT), 32'd0);
        check("rst_ef",  32'(EF),  32'd1);
        check("rst_aef", 32'(AEF), 32'd1);
        check("rst_aff", 32'(AFF), 32'd0);
        check("rst_ff",  32'(FF),  32'd0);
        check("rst_do",  32'(DO),  32'd0);
        check("rst_ovf", 32'(OVF), 32'd0);
        check("rst_udf", 32'(UDF), 32'd0);
        tick(); tick();
        RST = 1'b0;
        tick();

        // Three words in, three out.
        WE = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            DI = 8'(i);
            tick();
        end
        WE = 1'b0;
        check("w3_cnt", 32'(CNT), 32'd3);
        check("w3_ef",  32'(EF),  32'd0);
        RE = 1'b1;
        tick(); check("r1_do", 32'(DO), 32'd1); check("r1_ef", 32'(EF), 32'd0);
        tick(); check("r2_do", 32'(DO), 32'd2);
        tick(); check("r3_do", 32'(DO), 32'd3);
        RE = 1'b0;
        check("r3_ef",  32'(EF),  32'd1);
        check("r3_cnt", 32'(CNT), 32'd0);
        tick();
        check("hold_do", 32'(DO), 32'd3);

        // Fill to full, watching the threshold flags step by step.
        WE = 1'b1;
        for (int i = 0; i < 16; i++) begin
            DI = 8'(8'h10 + i);
            tick();
            check("fill_cnt", 32'(CNT), 32'(i + 1));
            check("fill_aef", 32'(AEF), 32'((i + 1) <= 2));
            check("fill_aff", 32'(AFF), 32'((i + 1) >= 14));
        end
        check("full_ff",  32'(FF),  32'd1);
        check("full_cnt", 32'(CNT), 32'd16);
        check("full_ovf0", 32'(OVF), 32'd0);
        DI = 8'hEE;
        tick();
        check("ovr_cnt", 32'(CNT), 32'd16);
        check("ovr_ovf", 32'(OVF), 32'(EXP_ERR));
        RE = 1'b1;
        DI = 8'hDD;
        tick();
        WE = 1'b0;
        check("fwr_cnt", 32'(CNT), 32'd15);
        check("fwr_ff",  32'(FF),  32'd0);
        check("fwr_do",  32'(DO),  32'h10);
        for (int i = 0; i < 15; i++) tick();
        RE = 1'b0;
        check("drain_do",  32'(DO),  32'h1F);
        check("drain_ef",  32'(EF),  32'd1);
        check("drain_ovf", 32'(OVF), 32'(EXP_ERR));
        ERRCLR = 1'b1;
        tick();
        ERRCLR = 1'b0;
        check("clr_ovf", 32'(OVF), 32'd0);

        // Simultaneous read/write on an empty FIFO: only the write lands.
        WE = 1'b1; RE = 1'b1; DI = 8'h55;
        tick();
        WE = 1'b0; RE = 1'b0;
        check("wre_cnt", 32'(CNT), 32'd1);
        check("wre_ef",  32'(EF),  32'd0);
        check("wre_udf", 32'(UDF), 32'(EXP_ERR));
        check("wre_do",  32'(DO),  32'h1F);
        RE = 1'b1;
        tick();
        RE = 1'b0;
        check("wre_rd", 32'(DO), 32'h55);

        // Flush with a coincident write and read.
        WE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            DI = 8'(8'h60 + i);
            tick();
        end
        check("pre_flush_cnt", 32'(CNT), 32'd5);
        RPRST = 1'b1; RE = 1'b1; DI = 8'h77;
        tick();
        RPRST = 1'b0; WE = 1'b0;
        check("flush_cnt", 32'(CNT), 32'd1);
        check("flush_do",  32'(DO),  32'h55);
        tick();
        RE = 1'b0;
        check("flush_rd",  32'(DO),  32'h77);
        check("flush_ef",  32'(EF),  32'd1);

        // Output register: capture gated by ORE, two edges after the read.
        WE = 1'b1;
        DI = 8'h81; tick();
        DI = 8'h82; tick();
        WE = 1'b0;
        RE = 1'b1;
        tick();
        RE = 1'b0; ORE = 1'b1;
        check("or_do1",   32'(DO),  32'h81);
        check("or_hold0", 32'(DO2), 32'd0);
        tick();
        check("or_do2",   32'(DO2), 32'h81);
        ORE = 1'b0; RE = 1'b1;
        tick();
        RE = 1'b0;
        check("or_rd2", 32'(DO), 32'h82);
        tick();
        check("or_hold1", 32'(DO2), 32'h81);
        ORE = 1'b1;
        tick();
        check("or_do3", 32'(DO2), 32'h82);

        // Reset in the middle of a burst clears state immediately.
        WE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            DI = 8'(8'h91 + i);
            tick();
        end
        WE = 1'b0; RE = 1'b1;
        tick(); tick();
        check("burst_do2", 32'(DO2), 32'h91);
        RST = 1'b1;
        #1;
        check("arst_do",  32'(DO),   32'd0);
        check("arst_do2", 32'(DO2),  32'd0);
        check("arst_ef",  32'(EF),   32'd1);
        check("arst_cnt", 32'(CNT),  32'd0);
        check("arst_cnt2", 32'(CNT2), 32'd0);
        RE = 1'b0; ORE = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        check("post_rst_ef", 32'(EF2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
